// File: rtl/chip8_fetch.sv
// Chip-8 fetch: reads opcode hi/lo bytes big-endian and presents {hi,lo} on a valid/ready port.
// Latency 3 cycles from ISSUE_HI to instr_valid; stalls in HOLD with no memory traffic while instr_ready=0.
module chip8_fetch #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h200
) (
  input  logic              cpu_clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_HI = 3'd1,
    ISSUE_LO = 3'd2,
    CAPTURE  = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INC1 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_INC2 = ADDR_W'(2);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [7:0]        hi;
  logic              accept;

  assign accept = instr_valid && instr_ready;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Redirect overrides every state, including an in-progress handshake.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = ISSUE_HI;
    end else begin
      case (state)
        IDLE:     state_nxt = ISSUE_HI;
        ISSUE_HI: state_nxt = ISSUE_LO;
        ISSUE_LO: state_nxt = CAPTURE;
        CAPTURE:  state_nxt = HOLD;
        HOLD:     if (accept) state_nxt = ISSUE_HI;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    case (state)
      ISSUE_HI: begin
        mem_rd   = 1'b1;
        mem_addr = fetch_pc;
      end
      ISSUE_LO: begin
        mem_rd   = 1'b1;
        mem_addr = fetch_pc + PC_INC1;
      end
      default: ;
    endcase
  end

  // Read data lags mem_rd by one cycle: hi arrives in ISSUE_LO, lo in CAPTURE.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      hi          <= 8'h00;
      instruction <= 16'h0000;
      instr_valid <= 1'b0;
      instr_pc    <= RESET_PC;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ISSUE_LO: hi <= mem_rdata;
        CAPTURE: begin
          instruction <= {hi, mem_rdata};
          instr_pc    <= fetch_pc;
          instr_valid <= 1'b1;
        end
        HOLD: begin
          if (accept) begin
            instr_valid <= 1'b0;
            fetch_pc    <= fetch_pc + PC_INC2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_fetch.sv
// Directed bench for chip8_fetch: expected read addresses and opcodes are queued by the
// stimulus and popped by a negedge monitor whenever the DUT reads memory or hands off an opcode.
module tb_chip8_fetch;
  localparam int AW = 12;

  logic          cpu_clk     = 1'b0;
  logic          reset       = 1'b1;
  logic          instr_ready = 1'b0;
  logic          redirect    = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [15:0]   instruction;
  logic          instr_valid;
  logic [AW-1:0] instr_pc;

  logic [7:0]    mem [0:4095];
  logic [AW-1:0] exp_addr [$];
  logic [27:0]   exp_ins  [$];   // {opcode, pc}
  logic [AW-1:0] ea;
  logic [27:0]   ei;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_hs  = 0;

  chip8_fetch #(.ADDR_W(AW), .RESET_PC(12'h200)) dut (
    .cpu_clk     (cpu_clk),
    .reset       (reset),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Synchronous byte memory: data is returned the cycle after the read strobe.
  always @(posedge cpu_clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  always @(negedge cpu_clk) begin
    if (reset === 1'b0) begin
      if (mem_rd === 1'b1) begin
        n_cmp++;
        if (exp_addr.size() == 0) begin
          n_err++;
          $display("FAIL rd_addr: read at %h, no read expected", mem_addr);
        end else begin
          ea = exp_addr.pop_front();
          if (mem_addr !== ea) begin
            n_err++;
            $display("FAIL rd_addr: got %h expected %h", mem_addr, ea);
          end
        end
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        n_hs++;
        n_cmp++;
        if (exp_ins.size() == 0) begin
          n_err++;
          $display("FAIL opcode: handshake of %h@%h, none expected", instruction, instr_pc);
        end else begin
          ei = exp_ins.pop_front();
          if ({instruction, instr_pc} !== ei) begin
            n_err++;
            $display("FAIL opcode: got %h@%h expected %h@%h",
                     instruction, instr_pc, ei[27:12], ei[11:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int i;
    i = 0;
    while (instr_valid !== 1'b1 && i < 16) begin
      tick();
      i++;
    end
    chk({name, "_valid_in_time"}, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem['h200] = 8'h61; mem['h201] = 8'h22; mem['h202] = 8'h60; mem['h203] = 8'h20;
    mem['h204] = 8'h80; mem['h205] = 8'h14; mem['h206] = 8'hA2; mem['h207] = 8'hF0;
    mem['h2A4] = 8'h6A; mem['h2A5] = 8'h5B;
    mem['h300] = 8'h13; mem['h301] = 8'h57;
    mem['hFFF] = 8'h12; mem['h000] = 8'h34;

    tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_instruction", 32'(instruction), 32'h0);
    chk("rst_instr_pc", 32'(instr_pc), 32'h200);
    tick();

    // Basic fetch, stream and backpressure.
    for (int a = 'h200; a <= 'h207; a++) exp_addr.push_back(AW'(a));
    exp_ins.push_back({16'h6122, 12'h200});
    exp_ins.push_back({16'h6020, 12'h202});
    exp_ins.push_back({16'h8014, 12'h204});
    reset = 1'b0;
    instr_ready = 1'b1;
    chk("idle_no_rd", 32'(mem_rd), 32'd0);
    tick();
    chk("first_rd", 32'(mem_rd), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'h200);
    tick();
    tick();
    chk("lat_capture_not_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(instr_valid), 32'd1);
    chk("first_op", 32'(instruction), 32'h6122);
    tick();
    chk("next_addr", 32'(mem_addr), 32'h202);
    instr_ready = 1'b0;
    wait_valid("op2");
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_op", 32'(instruction), 32'h6020);
      chk("stall_pc", 32'(instr_pc), 32'h202);
      chk("stall_no_rd", 32'(mem_rd), 32'd0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    wait_valid("op3");
    tick();
    instr_ready = 1'b0;

    // Redirect coinciding with a handshake in HOLD.
    wait_valid("op4");
    exp_ins.push_back({16'hA2F0, 12'h206});
    exp_addr.push_back(12'h2A4);
    exp_addr.push_back(12'h2A5);
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 12'h2A4;
    tick();
    redirect = 1'b0;
    instr_ready = 1'b0;
    chk("redir_hs_addr", 32'(mem_addr), 32'h2A4);
    chk("redir_hs_valid", 32'(instr_valid), 32'd0);
    exp_ins.push_back({16'h6A5B, 12'h2A4});
    exp_addr.push_back(12'h2A6);
    wait_valid("op5");
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Redirect during ISSUE_HI back to 0x200, then during ISSUE_LO of 0x202.
    exp_addr.push_back(12'h200);
    exp_addr.push_back(12'h201);
    redirect = 1'b1;
    redirect_pc = 12'h200;
    tick();
    redirect = 1'b0;
    exp_ins.push_back({16'h6122, 12'h200});
    exp_addr.push_back(12'h202);
    exp_addr.push_back(12'h203);
    instr_ready = 1'b1;
    wait_valid("op6");
    tick();
    instr_ready = 1'b0;
    tick();
    chk("lo_addr", 32'(mem_addr), 32'h203);
    exp_addr.push_back(12'h300);
    exp_addr.push_back(12'h301);
    exp_ins.push_back({16'h1357, 12'h300});
    redirect = 1'b1;
    redirect_pc = 12'h300;
    tick();
    redirect = 1'b0;
    chk("redir_mid_addr", 32'(mem_addr), 32'h300);
    instr_ready = 1'b1;
    wait_valid("op7");
    chk("redir_mid_pc", 32'(instr_pc), 32'h300);
    tick();
    instr_ready = 1'b0;

    // Odd target at the top of memory wraps to 0x000.
    exp_addr.push_back(12'h302);
    exp_addr.push_back(12'hFFF);
    exp_addr.push_back(12'h000);
    exp_ins.push_back({16'h1234, 12'hFFF});
    redirect = 1'b1;
    redirect_pc = 12'hFFF;
    tick();
    redirect = 1'b0;
    instr_ready = 1'b1;
    wait_valid("op8");
    chk("wrap_op", 32'(instruction), 32'h1234);
    chk("wrap_pc", 32'(instr_pc), 32'hFFF);
    exp_addr.push_back(12'h001);
    exp_addr.push_back(12'h002);
    tick();
    instr_ready = 1'b0;
    chk("wrap_next_addr", 32'(mem_addr), 32'h001);

    // Asynchronous reset between edges during CAPTURE.
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_mem_rd", 32'(mem_rd), 32'd0);
    chk("arst_instruction", 32'(instruction), 32'h0);
    chk("arst_instr_pc", 32'(instr_pc), 32'h200);
    tick();
    chk("arst_held_valid", 32'(instr_valid), 32'd0);
    for (int a = 'h200; a <= 'h203; a++) exp_addr.push_back(AW'(a));
    exp_ins.push_back({16'h6122, 12'h200});
    reset = 1'b0;
    chk("rel_idle_no_rd", 32'(mem_rd), 32'd0);
    tick();
    chk("rel_rd", 32'(mem_rd), 32'd1);
    chk("rel_addr", 32'(mem_addr), 32'h200);
    instr_ready = 1'b1;
    wait_valid("op9");
    tick();
    instr_ready = 1'b0;
    wait_valid("op10");

    chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
    chk("opcode_queue_drained", 32'(exp_ins.size()), 32'd0);
    chk("handshake_count", 32'(n_hs), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
